// File: rtl/ram_load_pkg.sv
// Shared types, default parameters and the byte-address to word-index helper
// for the RAM load arbiter.
package ram_load_pkg;

    localparam logic [31:0] DEFAULT_BASE_ADDR    = 32'h1000_0000;
    localparam int          DEFAULT_DEPTH_LOG2   = 12;
    localparam int          DEFAULT_IDLE_TIMEOUT = 24576;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN
    } state_t;

    // The two low byte-address bits are discarded by the shift.
    function automatic logic [31:0] addr_to_word(input logic [31:0] addr,
                                                 input logic [31:0] base);
        return (addr - base) >> 2;
    endfunction

endpackage

// File: rtl/ram_load_arbiter_if.sv
// Bus bundle between the arbiter, the UART word loader, the CPU LSU port and the RAM macro.
// Signal suffixes are seen from the arbiter; the slave modport is the arbiter side.
interface ram_load_arbiter_if
    import ram_load_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
);

    logic                  ld_valid_i;
    logic [31:0]           ld_addr_i;
    logic [31:0]           ld_data_i;
    logic                  ld_ready_o;

    logic                  cpu_req_i;
    logic                  cpu_we_i;
    logic [3:0]            cpu_be_i;
    logic [31:0]           cpu_addr_i;
    logic [31:0]           cpu_wdata_i;
    logic                  cpu_gnt_o;
    logic                  cpu_rvalid_o;
    logic [31:0]           cpu_rdata_o;

    logic                  ram_en_o;
    logic [3:0]            ram_we_o;
    logic [DEPTH_LOG2-1:0] ram_addr_o;
    logic [31:0]           ram_wdata_o;
    logic [31:0]           ram_rdata_i;

    modport slave (
        input  ld_valid_i, ld_addr_i, ld_data_i,
        output ld_ready_o,
        input  cpu_req_i, cpu_we_i, cpu_be_i, cpu_addr_i, cpu_wdata_i,
        output cpu_gnt_o, cpu_rvalid_o, cpu_rdata_o,
        output ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o,
        input  ram_rdata_i
    );

    modport master (
        output ld_valid_i, ld_addr_i, ld_data_i,
        input  ld_ready_o,
        output cpu_req_i, cpu_we_i, cpu_be_i, cpu_addr_i, cpu_wdata_i,
        input  cpu_gnt_o, cpu_rvalid_o, cpu_rdata_o,
        input  ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o,
        output ram_rdata_i
    );

endinterface

// File: rtl/ram_addr_decode.sv
// Maps a byte address onto the RAM word index and flags addresses outside
// the window [BASE_ADDR, BASE_ADDR + 4*2**DEPTH_LOG2).
module ram_addr_decode
    import ram_load_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = DEFAULT_BASE_ADDR,
    parameter int          DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
    input  logic [31:0]           addr_i,
    output logic                  in_range_o,
    output logic [DEPTH_LOG2-1:0] word_o
);

    logic [31:0] word_full;

    // Below-base addresses wrap to huge offsets, so both bounds are tested explicitly.
    always_comb begin
        word_full  = addr_to_word(addr_i, BASE_ADDR);
        in_range_o = (addr_i >= BASE_ADDR) && (word_full[31:DEPTH_LOG2] == '0);
        word_o     = word_full[DEPTH_LOG2-1:0];
    end

endmodule

// File: rtl/ram_load_arbiter.sv
// Owns the shared RAM port: boots by loading words from the UART loader while the CPU is held,
// then hands the port to the CPU. Optional LOAD_CHECKSUM_EN adds a running sum of loaded words.
module ram_load_arbiter
    import ram_load_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = DEFAULT_BASE_ADDR,
    parameter int          DEPTH_LOG2   = DEFAULT_DEPTH_LOG2,
    parameter int          IDLE_TIMEOUT = DEFAULT_IDLE_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              debug_en_i,
    ram_load_arbiter_if.slave bus,
    output logic              cpu_hold_o,
    output logic              load_busy_o,
    output logic [15:0]       word_cnt_o,
`ifdef LOAD_CHECKSUM_EN
    output logic [31:0]       checksum_o,
`endif
    output logic              err_o
);

    localparam int             CNT_W        = $clog2(IDLE_TIMEOUT);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(IDLE_TIMEOUT - 1);

    logic                  ld_in_range;
    logic [DEPTH_LOG2-1:0] ld_word;
    logic                  cpu_in_range;
    logic [DEPTH_LOG2-1:0] cpu_word;

    logic ld_fire;
    logic ld_write;
    logic cpu_gnt;

    state_t           state_q,    state_d;
    logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
    logic [15:0]      word_cnt_q, word_cnt_d;
    logic             err_q,      err_d;
    logic             hold_q,     hold_d;
    logic             busy_q,     busy_d;
    logic             rvalid_q,   rvalid_d;
    logic             rd_oor_q,   rd_oor_d;
`ifdef LOAD_CHECKSUM_EN
    logic [31:0]      checksum_q, checksum_d;
`endif

    ram_addr_decode #(
        .BASE_ADDR  (BASE_ADDR),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ld_decode (
        .addr_i     (bus.ld_addr_i),
        .in_range_o (ld_in_range),
        .word_o     (ld_word)
    );

    ram_addr_decode #(
        .BASE_ADDR  (BASE_ADDR),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_cpu_decode (
        .addr_i     (bus.cpu_addr_i),
        .in_range_o (cpu_in_range),
        .word_o     (cpu_word)
    );

    // An out-of-range loader word still counts as a loader word for arbitration and the FSM.
    always_comb begin
        ld_fire  = bus.ld_valid_i & debug_en_i;
        ld_write = ld_fire & ld_in_range;
        cpu_gnt  = bus.cpu_req_i & (state_q == S_RUN) & ~ld_fire;
    end

    always_comb begin
        bus.ram_en_o    = 1'b0;
        bus.ram_we_o    = 4'h0;
        bus.ram_addr_o  = '0;
        bus.ram_wdata_o = '0;
        if (ld_write) begin
            bus.ram_en_o    = 1'b1;
            bus.ram_we_o    = 4'hF;
            bus.ram_addr_o  = ld_word;
            bus.ram_wdata_o = bus.ld_data_i;
        end else if (cpu_gnt && cpu_in_range) begin
            bus.ram_en_o    = 1'b1;
            bus.ram_we_o    = bus.cpu_we_i ? bus.cpu_be_i : 4'h0;
            bus.ram_addr_o  = cpu_word;
            bus.ram_wdata_o = bus.cpu_wdata_i;
        end
    end

    // Next-state logic; the idle counter only runs in S_LOAD and restarts on every accepted word.
    always_comb begin
        state_d    = state_q;
        idle_cnt_d = '0;
        unique case (state_q)
            S_IDLE: begin
                if (ld_fire) begin
                    state_d = S_LOAD;
                end else if (!debug_en_i) begin
                    state_d = S_RUN;
                end
            end
            S_LOAD: begin
                if (ld_fire) begin
                    idle_cnt_d = '0;
                end else if (idle_cnt_q == TIMEOUT_LAST) begin
                    state_d = S_RUN;
                end else begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end
            end
            S_RUN: begin
                if (ld_fire) begin
                    state_d = S_LOAD;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A new load session started from S_RUN restarts the word statistics before counting.
    always_comb begin
        word_cnt_d = word_cnt_q;
        if (state_q == S_RUN && ld_fire) begin
            word_cnt_d = '0;
        end
        if (ld_write && word_cnt_d != 16'hFFFF) begin
            word_cnt_d = word_cnt_d + 16'd1;
        end

        err_d    = err_q | (ld_fire & ~ld_in_range) | (cpu_gnt & ~cpu_in_range);
        hold_d   = (state_d != S_RUN);
        busy_d   = (state_d == S_LOAD);
        rvalid_d = cpu_gnt & ~bus.cpu_we_i;
        rd_oor_d = cpu_gnt & ~cpu_in_range;
    end

`ifdef LOAD_CHECKSUM_EN
    always_comb begin
        checksum_d = checksum_q;
        if (state_q == S_RUN && ld_fire) begin
            checksum_d = '0;
        end
        if (ld_write) begin
            checksum_d = checksum_d + bus.ld_data_i;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            idle_cnt_q <= '0;
            word_cnt_q <= '0;
            err_q      <= 1'b0;
            hold_q     <= 1'b1;
            busy_q     <= 1'b0;
            rvalid_q   <= 1'b0;
            rd_oor_q   <= 1'b0;
`ifdef LOAD_CHECKSUM_EN
            checksum_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
            word_cnt_q <= word_cnt_d;
            err_q      <= err_d;
            hold_q     <= hold_d;
            busy_q     <= busy_d;
            rvalid_q   <= rvalid_d;
            rd_oor_q   <= rd_oor_d;
`ifdef LOAD_CHECKSUM_EN
            checksum_q <= checksum_d;
`endif
        end
    end

    // Reads that missed the RAM window return zero instead of stale RAM output.
    always_comb begin
        bus.ld_ready_o   = ld_fire;
        bus.cpu_gnt_o    = cpu_gnt;
        bus.cpu_rvalid_o = rvalid_q;
        bus.cpu_rdata_o  = (rvalid_q && !rd_oor_q) ? bus.ram_rdata_i : 32'h0;
        cpu_hold_o       = hold_q;
        load_busy_o      = busy_q;
        word_cnt_o       = word_cnt_q;
        err_o            = err_q;
`ifdef LOAD_CHECKSUM_EN
        checksum_o       = checksum_q;
`endif
    end

endmodule

// File: tb/tb_ram_load_arbiter.sv
// Directed bench for ram_load_arbiter with a behavioural 1-cycle-latency RAM;
// also covers checksum_o when built with LOAD_CHECKSUM_EN.
module tb_ram_load_arbiter;

    localparam int DEPTH_LOG2   = 12;
    localparam int IDLE_TIMEOUT = 16;
    localparam int RAM_WORDS    = 1 << DEPTH_LOG2;

    logic        clk;
    logic        rst;
    logic        debug_en;
    logic        cpu_hold;
    logic        load_busy;
    logic [15:0] word_cnt;
    logic        err;
`ifdef LOAD_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    int checks;
    int errors;

    ram_load_arbiter_if #(.DEPTH_LOG2(DEPTH_LOG2)) bus ();

    ram_load_arbiter #(
        .BASE_ADDR    (32'h1000_0000),
        .DEPTH_LOG2   (DEPTH_LOG2),
        .IDLE_TIMEOUT (IDLE_TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .debug_en_i  (debug_en),
        .bus         (bus),
        .cpu_hold_o  (cpu_hold),
        .load_busy_o (load_busy),
        .word_cnt_o  (word_cnt),
`ifdef LOAD_CHECKSUM_EN
        .checksum_o  (checksum),
`endif
        .err_o       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM macro: byte-enabled writes, registered read data on read accesses only.
    logic [31:0] mem [0:RAM_WORDS-1];
    logic        mem_clear;

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < RAM_WORDS; i++) mem[i] <= 32'h0;
            bus.ram_rdata_i <= 32'h0;
        end else if (bus.ram_en_o) begin
            if (bus.ram_we_o == 4'h0) bus.ram_rdata_i <= mem[bus.ram_addr_o];
            for (int b = 0; b < 4; b++) begin
                if (bus.ram_we_o[b]) mem[bus.ram_addr_o][8*b +: 8] <= bus.ram_wdata_o[8*b +: 8];
            end
        end
    end

    typedef struct {
        logic        debug_en;
        logic        ld_valid;
        logic [31:0] ld_addr;
        logic        cpu_req;
        logic        cpu_we;
        logic [3:0]  cpu_be;
        logic [31:0] cpu_addr;
        logic        exp_ld_ready;
        logic        exp_gnt;
        logic        exp_en;
        logic [3:0]  exp_we;
        logic [11:0] exp_addr;
    } vec_t;

    vec_t vecs [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic checkBit(input string name, input logic actual, input logic expected);
        checkOutput(name, {31'b0, actual}, {31'b0, expected});
    endtask

    task automatic idleInputs();
        bus.ld_valid_i  = 1'b0;
        bus.ld_addr_i   = 32'h0;
        bus.ld_data_i   = 32'h0;
        bus.cpu_req_i   = 1'b0;
        bus.cpu_we_i    = 1'b0;
        bus.cpu_be_i    = 4'h0;
        bus.cpu_addr_i  = 32'h0;
        bus.cpu_wdata_i = 32'h0;
    endtask

    task automatic loaderWord(input logic [31:0] addr, input logic [31:0] data);
        bus.ld_valid_i = 1'b1;
        bus.ld_addr_i  = addr;
        bus.ld_data_i  = data;
    endtask

    task automatic cpuAccess(input logic we, input logic [3:0] be, input logic [31:0] addr, input logic [31:0] wdata);
        bus.cpu_req_i   = 1'b1;
        bus.cpu_we_i    = we;
        bus.cpu_be_i    = be;
        bus.cpu_addr_i  = addr;
        bus.cpu_wdata_i = wdata;
    endtask

    task automatic applyStimulus(input vec_t v);
        debug_en        = v.debug_en;
        bus.ld_valid_i  = v.ld_valid;
        bus.ld_addr_i   = v.ld_addr;
        bus.ld_data_i   = 32'h0;
        bus.cpu_req_i   = v.cpu_req;
        bus.cpu_we_i    = v.cpu_we;
        bus.cpu_be_i    = v.cpu_be;
        bus.cpu_addr_i  = v.cpu_addr;
        bus.cpu_wdata_i = 32'hCAFE_F00D;
    endtask

    initial begin
        logic [31:0] exp_sum;
        checks = 0;
        errors = 0;
        exp_sum = 32'hDEADBEEF + 32'h01234567;

        // debug, ldv, ld_addr, req, we, be, cpu_addr -> ld_ready, gnt, en, we, word addr
        vecs[0] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 4'h0, 32'h1000_0010, 1'b0, 1'b1, 1'b1, 4'h0, 12'h004};
        vecs[1] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 4'hF, 32'h1000_3FFC, 1'b0, 1'b1, 1'b1, 4'hF, 12'hFFF};
        vecs[2] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 4'h4, 32'h1000_0007, 1'b0, 1'b1, 1'b1, 4'h4, 12'h001};
        vecs[3] = '{1'b0, 1'b1, 32'h1000_0020, 1'b0, 1'b0, 4'h0, 32'h0,         1'b0, 1'b0, 1'b0, 4'h0, 12'h000};
        vecs[4] = '{1'b0, 1'b1, 32'h1000_0024, 1'b1, 1'b0, 4'h0, 32'h1000_0000, 1'b0, 1'b1, 1'b1, 4'h0, 12'h000};
        vecs[5] = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 4'h0, 32'h0,         1'b0, 1'b0, 1'b0, 4'h0, 12'h000};

        idleInputs();
        debug_en  = 1'b1;
        rst       = 1'b1;
        mem_clear = 1'b1;
        tick();
        tick();
        mem_clear = 1'b0;

        checkBit("reset_hold", cpu_hold, 1'b1);
        checkBit("reset_busy", load_busy, 1'b0);
        checkOutput("reset_word_cnt", {16'h0, word_cnt}, 32'h0);
        checkBit("reset_err", err, 1'b0);
        checkBit("reset_rvalid", bus.cpu_rvalid_o, 1'b0);
`ifdef LOAD_CHECKSUM_EN
        checkOutput("reset_checksum", checksum, 32'h0);
`endif

        rst = 1'b0;
        tick();
        tick();
        tick();
        checkBit("idle_wait_hold", cpu_hold, 1'b1);
        checkBit("idle_wait_busy", load_busy, 1'b0);

        // T1 boot load
        loaderWord(32'h1000_0000, 32'hDEADBEEF);
        #1;
        checkBit("t1_w0_ready", bus.ld_ready_o, 1'b1);
        checkBit("t1_w0_en", bus.ram_en_o, 1'b1);
        checkOutput("t1_w0_we", {28'h0, bus.ram_we_o}, 32'hF);
        checkOutput("t1_w0_addr", {20'h0, bus.ram_addr_o}, 32'h0);
        tick();
        loaderWord(32'h1000_0004, 32'h01234567);
        #1;
        checkOutput("t1_w1_addr", {20'h0, bus.ram_addr_o}, 32'h1);
        tick();
        idleInputs();
        checkOutput("t1_ram0", mem[0], 32'hDEADBEEF);
        checkOutput("t1_ram1", mem[1], 32'h01234567);
        checkOutput("t1_word_cnt", {16'h0, word_cnt}, 32'd2);
        checkBit("t1_hold", cpu_hold, 1'b1);
        checkBit("t1_busy", load_busy, 1'b1);
`ifdef LOAD_CHECKSUM_EN
        checkOutput("t1_checksum", checksum, exp_sum);
`endif

        // T2 hold falls on the 16th edge after the last word
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k == 15) checkBit("t2_hold_before", cpu_hold, 1'b1);
            if (k == 16) begin
                checkBit("t2_hold_after", cpu_hold, 1'b0);
                checkBit("t2_busy_after", load_busy, 1'b0);
            end
        end

        // T3 CPU partial write then read back
        cpuAccess(1'b1, 4'b0011, 32'h1000_0008, 32'hAABBCCDD);
        #1;
        checkBit("t3_wr_gnt", bus.cpu_gnt_o, 1'b1);
        checkOutput("t3_wr_we", {28'h0, bus.ram_we_o}, 32'h3);
        checkOutput("t3_wr_addr", {20'h0, bus.ram_addr_o}, 32'h2);
        tick();
        cpuAccess(1'b0, 4'h0, 32'h1000_0008, 32'h0);
        #1;
        checkBit("t3_rd_gnt", bus.cpu_gnt_o, 1'b1);
        checkBit("t3_rvalid_after_wr", bus.cpu_rvalid_o, 1'b0);
        tick();
        idleInputs();
        checkBit("t3_rvalid", bus.cpu_rvalid_o, 1'b1);
        checkOutput("t3_rdata", bus.cpu_rdata_o, 32'h0000CCDD);
        tick();
        checkBit("t3_rvalid_drop", bus.cpu_rvalid_o, 1'b0);

        // Table of single-cycle arbitration/decode vectors in S_RUN
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i]);
            #1;
            checkBit($sformatf("vec%0d_ld_ready", i), bus.ld_ready_o, vecs[i].exp_ld_ready);
            checkBit($sformatf("vec%0d_gnt", i), bus.cpu_gnt_o, vecs[i].exp_gnt);
            checkBit($sformatf("vec%0d_en", i), bus.ram_en_o, vecs[i].exp_en);
            checkOutput($sformatf("vec%0d_we", i), {28'h0, bus.ram_we_o}, {28'h0, vecs[i].exp_we});
            if (vecs[i].exp_en)
                checkOutput($sformatf("vec%0d_addr", i), {20'h0, bus.ram_addr_o}, {20'h0, vecs[i].exp_addr});
            tick();
        end
        idleInputs();
        debug_en = 1'b1;
        tick();
        checkBit("table_still_run", cpu_hold, 1'b0);
        checkBit("table_err_clear", err, 1'b0);

        // T4 loader beats CPU in the same S_RUN cycle
        loaderWord(32'h1000_0030, 32'h55AA55AA);
        cpuAccess(1'b1, 4'hF, 32'h1000_0040, 32'h11111111);
        #1;
        checkBit("t4_ld_ready", bus.ld_ready_o, 1'b1);
        checkBit("t4_cpu_gnt", bus.cpu_gnt_o, 1'b0);
        checkOutput("t4_addr", {20'h0, bus.ram_addr_o}, 32'hC);
        checkOutput("t4_wdata", bus.ram_wdata_o, 32'h55AA55AA);
        tick();
        idleInputs();
        checkBit("t4_hold", cpu_hold, 1'b1);
        checkBit("t4_busy", load_busy, 1'b1);
        checkOutput("t4_word_cnt", {16'h0, word_cnt}, 32'd1);
        checkOutput("t4_ram_ld", mem[12], 32'h55AA55AA);
        checkOutput("t4_ram_cpu", mem[16], 32'h0);
`ifdef LOAD_CHECKSUM_EN
        checkOutput("t4_checksum", checksum, 32'h55AA55AA);
`endif

        // T5 out-of-range loader word then out-of-range CPU read
        loaderWord(32'h0FFF_FFFC, 32'h12345678);
        #1;
        checkBit("t5_ld_ready", bus.ld_ready_o, 1'b1);
        checkBit("t5_ld_en", bus.ram_en_o, 1'b0);
        tick();
        idleInputs();
        checkBit("t5_err", err, 1'b1);
        checkOutput("t5_word_cnt", {16'h0, word_cnt}, 32'd1);
        checkOutput("t5_ram_top", mem[RAM_WORDS-1], 32'hCAFEF00D);
`ifdef LOAD_CHECKSUM_EN
        checkOutput("t5_checksum", checksum, 32'h55AA55AA);
`endif
        for (int k = 0; k < 40 && cpu_hold; k++) tick();
        checkBit("t5_reached_run", cpu_hold, 1'b0);
        cpuAccess(1'b0, 4'h0, 32'h1000_4000, 32'h0);
        #1;
        checkBit("t5_cpu_gnt", bus.cpu_gnt_o, 1'b1);
        checkBit("t5_cpu_en", bus.ram_en_o, 1'b0);
        tick();
        idleInputs();
        checkBit("t5_rvalid", bus.cpu_rvalid_o, 1'b1);
        checkOutput("t5_rdata", bus.cpu_rdata_o, 32'h0);
        checkBit("t5_err_sticky", err, 1'b1);

        // T6 debug disabled: straight to S_RUN, loader ignored
        debug_en = 1'b0;
        rst      = 1'b1;
        tick();
        tick();
        checkBit("t6_reset_err", err, 1'b0);
        checkBit("t6_reset_hold", cpu_hold, 1'b1);
        rst = 1'b0;
        tick();
        checkBit("t6_hold", cpu_hold, 1'b0);
        checkBit("t6_busy", load_busy, 1'b0);
        loaderWord(32'h1000_0050, 32'h77777777);
        #1;
        checkBit("t6_ld_ready", bus.ld_ready_o, 1'b0);
        checkBit("t6_ld_en", bus.ram_en_o, 1'b0);
        tick();
        idleInputs();
        checkBit("t6_hold_after", cpu_hold, 1'b0);
        checkOutput("t6_ram", mem[20], 32'h0);
        checkOutput("t6_ram_kept", mem[0], 32'hDEADBEEF);

        // T7 debug drops mid-load: ignored pulses do not restart the timeout
        debug_en = 1'b1;
        rst      = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        loaderWord(32'h1000_0060, 32'h0BADF00D);
        tick();
        idleInputs();
        debug_en = 1'b0;
        checkOutput("t7_word_cnt", {16'h0, word_cnt}, 32'd1);
`ifdef LOAD_CHECKSUM_EN
        checkOutput("t7_checksum", checksum, 32'h0BADF00D);
`endif
        for (int k = 1; k <= 16; k++) begin
            if (k == 5) begin
                loaderWord(32'h1000_0064, 32'h1);
                #1;
                checkBit("t7_ld_ready", bus.ld_ready_o, 1'b0);
                checkBit("t7_ld_en", bus.ram_en_o, 1'b0);
            end
            tick();
            idleInputs();
            if (k == 15) checkBit("t7_hold_before", cpu_hold, 1'b1);
            if (k == 16) checkBit("t7_hold_after", cpu_hold, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
